// File: rtl/vend_change_sequencer.sv
// Greedy coin-change payout sequencer: one coin per eject_req/eject_ack handshake.
// Optional per-coin stock and refill under macro COIN_INVENTORY_EN.
module vend_change_sequencer
`ifdef COIN_INVENTORY_EN
   #(parameter int unsigned INIT_STOCK = 20)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [8:0] amount,
   input  logic       abort,
   input  logic       eject_ack,
`ifdef COIN_INVENTORY_EN
   input  logic       refill,
`endif
   output logic       eject_req,
   output logic [1:0] eject_sel,
   output logic       busy,
   output logic       done,
   output logic       short,
   output logic [8:0] shortfall,
   output logic [5:0] quart,
   output logic [5:0] dim,
   output logic [5:0] nick,
   output logic [5:0] pen
);

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_DONE} state_t;

   state_t     state_q, state_d;
   logic [8:0] remaining_q, remaining_d;
   logic [8:0] shortfall_q, shortfall_d;
   logic [5:0] cnt_q [4];
   logic [5:0] cnt_d [4];
   logic       eject_req_q, eject_req_d;
   logic [1:0] eject_sel_q, eject_sel_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       short_q, short_d;
   logic [3:0] avail;
   logic       pick_vld;
   logic [1:0] pick_sel;
`ifdef COIN_INVENTORY_EN
   logic [5:0] stock_q [4];
   logic [5:0] stock_d [4];
`endif

   function automatic logic [8:0] coin_val(input logic [1:0] sel);
      case (sel)
         2'd0:    coin_val = 9'd25;
         2'd1:    coin_val = 9'd10;
         2'd2:    coin_val = 9'd5;
         default: coin_val = 9'd1;
      endcase
   endfunction

`ifdef COIN_INVENTORY_EN
   always_comb begin
      for (int i = 0; i < 4; i++) avail[i] = (stock_q[i] != 6'd0);
   end
`else
   assign avail = 4'hf;
`endif

   // Scan smallest to largest so the largest eligible coin wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_sel = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (avail[i] && (remaining_q >= coin_val(2'(i)))) begin
            pick_vld = 1'b1;
            pick_sel = 2'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      shortfall_d = shortfall_q;
      cnt_d       = cnt_q;
      eject_req_d = eject_req_q;
      eject_sel_d = eject_sel_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      short_d     = short_q;
`ifdef COIN_INVENTORY_EN
      stock_d     = stock_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef COIN_INVENTORY_EN
            if (refill) begin
               for (int i = 0; i < 4; i++) stock_d[i] = 6'(INIT_STOCK);
            end
`endif
            if (start) begin
               state_d     = S_SELECT;
               remaining_d = amount;
               shortfall_d = 9'd0;
               short_d     = 1'b0;
               busy_d      = 1'b1;
               for (int i = 0; i < 4; i++) cnt_d[i] = 6'd0;
            end
         end
         S_SELECT: begin
            if (remaining_q == 9'd0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (abort || !pick_vld) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               short_d     = 1'b1;
               shortfall_d = remaining_q;
            end else begin
               state_d     = S_EJECT;
               eject_req_d = 1'b1;
               eject_sel_d = pick_sel;
            end
         end
         S_EJECT: begin
            if (eject_ack) begin
               state_d              = S_SELECT;
               eject_req_d          = 1'b0;
               remaining_d          = remaining_q - coin_val(eject_sel_q);
               cnt_d[eject_sel_q]   = cnt_q[eject_sel_q] + 6'd1;
`ifdef COIN_INVENTORY_EN
               stock_d[eject_sel_q] = stock_q[eject_sel_q] - 6'd1;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         remaining_q <= 9'd0;
         shortfall_q <= 9'd0;
         eject_req_q <= 1'b0;
         eject_sel_q <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         short_q     <= 1'b0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= 6'd0;
`ifdef COIN_INVENTORY_EN
         for (int i = 0; i < 4; i++) stock_q[i] <= 6'(INIT_STOCK);
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         shortfall_q <= shortfall_d;
         eject_req_q <= eject_req_d;
         eject_sel_q <= eject_sel_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         short_q     <= short_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
`ifdef COIN_INVENTORY_EN
         for (int i = 0; i < 4; i++) stock_q[i] <= stock_d[i];
`endif
      end
   end

   assign eject_req = eject_req_q;
   assign eject_sel = eject_sel_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign short     = short_q;
   assign shortfall = shortfall_q;
   assign quart     = cnt_q[0];
   assign dim       = cnt_q[1];
   assign nick      = cnt_q[2];
   assign pen       = cnt_q[3];

endmodule

// File: doc/vend_change_sequencer.md
VEND_CHANGE_SEQUENCER -- requirements
Module: vend_change_sequencer

Interface
REQ-001 Parameter: INIT_STOCK, 20, reset/refill count per coin type; used only with COIN_INVENTORY_EN.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  request a payout of amount; sampled only in IDLE.
REQ-005 amount  in  9  change owed, in cents (0..511); sampled when start is accepted.
REQ-006 abort  in  1  stop the payout early; honoured only in SELECT.
REQ-007 eject_ack  in  1  coin hopper confirms the requested coin was ejected.
REQ-008 eject_req  out  1  request that the hopper eject one coin.
REQ-009 eject_sel  out  2  coin to eject: 00 quarter (25), 01 dime (10), 10 nickel (5), 11 penny (1).
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle pulse at payout end.
REQ-012 short  out  1  the last payout ended with a nonzero remainder.
REQ-013 shortfall  out  9  cents not paid by the last payout.
REQ-014 quart, dim, nick, pen  out  6 each  coins ejected per type in the current or last payout.
REQ-015 refill  in  1  reload all coin stocks; present only with COIN_INVENTORY_EN.

Function
REQ-016 FSM states and transitions:
- IDLE: start -> SELECT.
- SELECT: -> EJECT, or -> DONE.
- EJECT: eject_ack -> SELECT.
- DONE: -> IDLE unconditionally.
REQ-017 Accepting start in IDLE at cycle t:
- remaining <= amount.
- All counts, short and shortfall cleared.
- SELECT at t+1.
REQ-018 SELECT, decided in one cycle, priority order:
- remaining==0 -> DONE.
- abort -> DONE with short=1, shortfall=remaining.
- Otherwise choose the largest coin with value <= remaining and stock > 0 -> EJECT.
- No eligible coin -> DONE with short=1, shortfall=remaining.
REQ-019 eject_req and eject_sel are registered outputs: high and stable for every EJECT cycle, low/held otherwise.
REQ-020 Handshake: eject_req stays asserted until eject_ack is sampled high; abort is ignored in EJECT; eject_ack outside EJECT is ignored.
REQ-021 On eject_ack in EJECT:
- remaining decreases by the coin value.
- The matching count increments by 1.
- The coin stock decrements by 1.
- State returns to SELECT.
- The next eject_req is therefore no earlier than 2 cycles after the ack.
REQ-022 done is high for exactly the one DONE cycle; an amount of 0 gives done at t+2 with no eject_req.
REQ-023 start while busy is ignored; amount may change freely while busy without effect.
REQ-024 Counts, short and shortfall hold their value after DONE until the next accepted start.
REQ-025 remaining never underflows; a count never exceeds 63 (stock limited, or greedy bound without inventory).

Reset
REQ-026 rst_n low immediately forces:
- IDLE.
- eject_req=0, eject_sel=00.
- busy=0, done=0, short=0.
- shortfall=0, remaining=0, all counts 0.
- Stocks = INIT_STOCK.
REQ-027 Reset asserted mid-EJECT drops eject_req in the same cycle; the coin in flight is not counted.
REQ-028 Leaving reset starts in IDLE; no eject_req until a start is accepted.

Configuration
REQ-029 Macro COIN_INVENTORY_EN defined:
- Four 6-bit stock counters.
- refill port present: refill high in IDLE sets every stock to INIT_STOCK; ignored when busy.
- A coin with stock 0 is never selected.
REQ-030 COIN_INVENTORY_EN undefined:
- Stock is unlimited and no refill port exists.
- Payout is pure greedy.
- short=1 only via abort.

Verification
REQ-031 amount=67, eject_ack one cycle after each eject_req:
- Ejects Q,Q,D,N,P,P.
- quart=2, dim=1, nick=1, pen=2.
- short=0, one done pulse.
REQ-032 amount=0: done at t+2, eject_req never asserted, all counts 0.
REQ-033 amount=30, eject_ack delayed 4 cycles on the first coin:
- eject_req=1 and eject_sel=00 held steady for all 4 cycles.
- Then the nickel is ejected.
- quart=1, nick=1.
REQ-034 COIN_INVENTORY_EN with quarter stock 1, amount=50:
- Ejects Q,D,D,N; short=0.
- A second amount=30 gives D,D,D.
REQ-035 COIN_INVENTORY_EN with quarter, dime and nickel stock 0, penny stock 2, amount=7:
- Ejects P,P.
- short=1, shortfall=5.
REQ-036 amount=40, abort asserted in the SELECT after the first ack: done with quart=1, short=1, shortfall=15.
REQ-037 amount=40, rst_n pulsed low mid-EJECT: eject_req=0 immediately, state IDLE, counts 0.
